// File: rtl/divider_seq_param.sv
// Sequential restoring divider, WIDTH-bit unsigned operands, MSB first.
// Optional build macro: DIVIDER_SIGNED_EN (adds the signed_mode input).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   start        request, sampled only in IDLE
//   signed_mode  two's-complement operands (DIVIDER_SIGNED_EN builds only)
//   A, B         dividend / divisor, sampled with start
//   busy         high in RUN and FIN
//   done         one-cycle pulse, Q/R/err valid from this cycle
//   err          divide-by-zero flag
//   Q, R         quotient / remainder, held until the next result
module divider_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIVIDER_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_err;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg_q;
    logic             w_neg_r;
    logic             w_b_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Signed operation divides magnitudes; the most negative value
    // maps to its own bit pattern, which is the correct unsigned magnitude.
`ifdef DIVIDER_SIGNED_EN
    assign w_a_mag = (signed_mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign w_b_mag = (signed_mode && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign w_neg_q = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    assign w_neg_r = signed_mode & A[WIDTH-1];
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_neg_q = 1'b0;
    assign w_neg_r = 1'b0;
`endif

    assign w_b_zero = (B == '0);
    assign w_last   = (r_cnt == CW'(1));

    // One restoring step: the dividend register shifts out its MSB into
    // the partial remainder and collects quotient bits at its LSB.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_dvs};
    assign w_qbit   = ~w_trial[WIDTH];
    assign w_rem_nx = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nx = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_q_fix  = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_r_fix  = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = w_b_zero ? S_FIN : S_RUN;
            S_RUN:  if (w_last) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_err   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                if (w_b_zero) begin
                    r_q   <= '1;
                    r_r   <= A;
                    r_err <= 1'b1;
                end else begin
                    r_dvd   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_rem   <= '0;
                    r_cnt   <= CW'(WIDTH);
                    r_err   <= 1'b0;
                    r_neg_q <= w_neg_q;
                    r_neg_r <= w_neg_r;
                end
            end else if (r_state == S_RUN) begin
                r_rem <= w_rem_nx;
                r_dvd <= w_quo_nx;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_q <= w_q_fix;
                    r_r <= w_r_fix;
                end
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_FIN);
    assign err  = r_err;
    assign Q    = r_q;
    assign R    = r_r;

endmodule

// File: tb/tb_divider_seq_param.sv
// Directed and scoreboard bench for divider_seq_param.
// Covers WIDTH=8 and a WIDTH=16 instance sharing clock and reset.
module tb_divider_seq_param;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sm;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  Q;
    logic [7:0]  R;

    logic        start16;
    logic        sm16;
    logic [15:0] A16;
    logic [15:0] B16;
    logic        busy16;
    logic        done16;
    logic        err16;
    logic [15:0] Q16;
    logic [15:0] R16;

    int n_total = 0;
    int n_bad   = 0;

    divider_seq_param #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef DIVIDER_SIGNED_EN
        .signed_mode (sm),
`endif
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .Q     (Q),
        .R     (R)
    );

    divider_seq_param #(.WIDTH(16)) u_d16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
`ifdef DIVIDER_SIGNED_EN
        .signed_mode (sm16),
`endif
        .A     (A16),
        .B     (B16),
        .busy  (busy16),
        .done  (done16),
        .err   (err16),
        .Q     (Q16),
        .R     (R16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for done. lat counts clock edges after
    // the sampling edge until done is first seen (0 = high right after it).
    // e0 is err just after the sampling edge; bz is 0 if busy ever dropped.
    task automatic div8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic e, output int lat,
                        output logic e0, output logic bz);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 8'h5a;
        B = 8'h00;
        e0 = err;
        bz = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin
            if (!busy) bz = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) bz = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        q = Q;
        r = R;
        e = err;
        @(posedge clk);
        #1;
    endtask

    task automatic div16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic e);
        int n;
        A16 = a;
        B16 = b;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done16_seen", {31'd0, done16}, 32'd1);
        q = Q16;
        r = R16;
        e = err16;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  q8;
    logic [7:0]  r8;
    logic [15:0] q16;
    logic [15:0] r16;
    logic        e;
    logic        e0;
    logic        bz;
    logic        saw_done;
    int          lat;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        start16 = 1'b0;
        sm = 1'b0;
        sm16 = 1'b0;
        A = '0;
        B = '0;
        A16 = '0;
        B16 = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_q", {24'd0, Q}, 32'd0);
        chk("rst_r", {24'd0, R}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        div8(8'd174, 8'd25, q8, r8, e, lat, e0, bz);
        chk("174_lat", lat, 32'd8);
        chk("174_q", {24'd0, q8}, 32'd6);
        chk("174_r", {24'd0, r8}, 32'd24);
        chk("174_err", {31'd0, e}, 32'd0);
        chk("174_busy", {31'd0, bz}, 32'd1);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("hold_q", {24'd0, Q}, 32'd6);

        div8(8'd10, 8'd25, q8, r8, e, lat, e0, bz);
        chk("10_q", {24'd0, q8}, 32'd0);
        chk("10_r", {24'd0, r8}, 32'd10);
        div8(8'd50, 8'd50, q8, r8, e, lat, e0, bz);
        chk("50_q", {24'd0, q8}, 32'd1);
        chk("50_r", {24'd0, r8}, 32'd0);
        div8(8'd0, 8'd25, q8, r8, e, lat, e0, bz);
        chk("0_q", {24'd0, q8}, 32'd0);
        chk("0_r", {24'd0, r8}, 32'd0);

        div8(8'd37, 8'd0, q8, r8, e, lat, e0, bz);
        chk("dz_lat", lat, 32'd0);
        chk("dz_err", {31'd0, e}, 32'd1);
        chk("dz_q", {24'd0, q8}, 32'd255);
        chk("dz_r", {24'd0, r8}, 32'd37);
        div8(8'd0, 8'd0, q8, r8, e, lat, e0, bz);
        chk("dz0_err", {31'd0, e}, 32'd1);
        chk("dz0_q", {24'd0, q8}, 32'd255);
        chk("dz0_r", {24'd0, r8}, 32'd0);
        chk("err_hold", {31'd0, err}, 32'd1);
        div8(8'd9, 8'd3, q8, r8, e, lat, e0, bz);
        chk("err_clr_start", {31'd0, e0}, 32'd0);
        chk("9_q", {24'd0, q8}, 32'd3);
        chk("9_err", {31'd0, e}, 32'd0);

        // Second start pulsed mid-operation must be ignored.
        A = 8'd200;
        B = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bz = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin
            if (!busy) bz = 1'b0;
            if (lat == 2) begin
                A = 8'd9;
                B = 8'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_lat", lat, 32'd8);
        chk("ign_q", {24'd0, Q}, 32'd28);
        chk("ign_r", {24'd0, R}, 32'd4);
        chk("ign_busy", {31'd0, bz}, 32'd1);
        // Start held through FIN is ignored; idle follows.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fin_start_ign", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN aborts with no done.
        A = 8'd255;
        B = 8'd16;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abt_busy", {31'd0, busy}, 32'd0);
        chk("abt_q", {24'd0, Q}, 32'd0);
        chk("abt_r", {24'd0, R}, 32'd0);
        chk("abt_err", {31'd0, err}, 32'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abt_nodone", {31'd0, saw_done}, 32'd0);
        div8(8'd255, 8'd16, q8, r8, e, lat, e0, bz);
        chk("255_q", {24'd0, q8}, 32'd15);
        chk("255_r", {24'd0, r8}, 32'd15);

`ifdef DIVIDER_SIGNED_EN
        sm = 1'b1;
        div8(8'hf9, 8'h02, q8, r8, e, lat, e0, bz);
        chk("s_m7_q", {24'd0, q8}, 32'hfd);
        chk("s_m7_r", {24'd0, r8}, 32'hff);
        div8(8'h07, 8'hfe, q8, r8, e, lat, e0, bz);
        chk("s_7_q", {24'd0, q8}, 32'hfd);
        chk("s_7_r", {24'd0, r8}, 32'h01);
        div8(8'h80, 8'hff, q8, r8, e, lat, e0, bz);
        chk("s_min_q", {24'd0, q8}, 32'h80);
        chk("s_min_r", {24'd0, r8}, 32'h00);
        chk("s_min_err", {31'd0, e}, 32'd0);
        chk("s_min_lat", lat, 32'd8);
        sm = 1'b0;
`endif

        for (int i = 0; i < 100; i++) begin
            int a;
            int b;
            int eq;
            int er;
            a = $urandom_range(255, 0);
            b = (i % 10 == 3) ? 0 : $urandom_range(255, 0);
            eq = (b == 0) ? 255 : a / b;
            er = (b == 0) ? a : a % b;
            div8(a[7:0], b[7:0], q8, r8, e, lat, e0, bz);
            chk("rnd8_q", {24'd0, q8}, eq);
            chk("rnd8_r", {24'd0, r8}, er);
            chk("rnd8_err", {31'd0, e}, (b == 0) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            int eq;
            int er;
            a = $urandom_range(65535, 0);
            b = (i % 8 == 5) ? 0 : $urandom_range(65535, 0);
            if (i % 8 == 2) b = $urandom_range(15, 1);
            eq = (b == 0) ? 65535 : a / b;
            er = (b == 0) ? a : a % b;
            div16(a[15:0], b[15:0], q16, r16, e);
            chk("rnd16_q", {16'd0, q16}, eq);
            chk("rnd16_r", {16'd0, r16}, er);
            chk("rnd16_err", {31'd0, e}, (b == 0) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
